// File: rtl/hack_prog_loader.sv
// Boot-time program loader: assembles big-endian 16-bit words from a byte stream,
// writes them into instruction memory from address 0, and holds the CPU in reset
// until the image (header word count followed by that many words) is complete.
module hack_prog_loader #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              restart,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    localparam int unsigned LEN_W = 16;
    localparam int unsigned CAP   = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_LEN_HI  = 3'd0,
        S_LEN_LO  = 3'd1,
        S_DATA_HI = 3'd2,
        S_DATA_LO = 3'd3,
        S_FINISH  = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [7:0]         hi_q, hi_d;
    logic               wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_d;
    logic [DATA_W-1:0]  wr_data_d;
    logic [LEN_W-1:0]   words_d;
    logic [LEN_W-1:0]   len_rx;
    logic               accept;

    // Byte handshake: ready only while parsing the header or payload.
    assign rx_ready = reset_n && (state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO});
    assign accept   = rx_valid && rx_ready;
    assign len_rx   = {len_q[15:8], rx_data};

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        hi_d      = hi_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        words_d   = words_loaded;
        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_rx;
                    if (len_rx == '0) begin
                        state_d = S_DONE;
                    end else if (32'(len_rx) > CAP) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    state_d = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'(words_loaded);
                    wr_data_d = DATA_W'({hi_q, rx_data});
                    words_d   = LEN_W'(words_loaded + 16'd1);
                    state_d   = (words_d == len_q) ? S_FINISH : S_DATA_HI;
                end
            end
            S_FINISH: begin
                state_d = S_DONE;
            end
            S_DONE, S_ERROR: begin
                if (restart) begin
                    state_d = S_LEN_HI;
                    words_d = '0;
                end
            end
            default: begin
                state_d = S_LEN_HI;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset aborts any load.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_LEN_HI;
            len_q        <= '0;
            hi_q         <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            words_loaded <= '0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            hi_q         <= hi_d;
            wr_en        <= wr_en_d;
            wr_addr      <= wr_addr_d;
            wr_data      <= wr_data_d;
            words_loaded <= words_d;
            cpu_reset    <= (state_d != S_DONE);
            done         <= (state_d == S_DONE);
            error        <= (state_d == S_ERROR);
        end
    end

endmodule

// File: tb/tb_hack_prog_loader.sv
// Self-checking bench for hack_prog_loader: directed and randomized image loads
// compared against a simple list-of-writes model of the byte stream format.
module tb_hack_prog_loader;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;
    localparam int CAP = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              restart;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cpu_reset;
    logic              done;
    logic              error;
    logic [15:0]       words_loaded;

    int tests = 0;
    int fails = 0;
    int restart_word = -1;

    logic [15:0] stim_q[$];
    logic [31:0] got_q[$];

    hack_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .restart(restart), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cpu_reset(cpu_reset), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    // Record every memory write seen by the instruction ROM.
    always @(negedge clock) begin
        if (wr_en === 1'b1) got_q.push_back({17'(wr_addr), wr_data});
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
        k = 0;
        while (rx_ready !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        tests++;
        if (rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_byte: rx_ready stayed %b, required 1 for byte %02h", rx_ready, b);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_restart();
        rx_valid = 1'b0;
        restart  = 1'b1;
        @(negedge clock);
        restart  = 1'b0;
    endtask

    // Stream header n plus stim_q[0..n-1]; model: word i lands at address i, then done.
    task automatic load_and_check(input int n, input int gmin, input int gmax, input string name);
        logic [15:0] nn;
        logic [31:0] exp;
        nn = 16'(n);
        got_q.delete();
        send_byte(nn[15:8], $urandom_range(gmax, gmin));
        send_byte(nn[7:0], $urandom_range(gmax, gmin));
        for (int i = 0; i < n; i++) begin
            if (i == restart_word) begin
                rx_valid = 1'b0;
                restart  = 1'b1;
                @(negedge clock);
                restart  = 1'b0;
            end
            send_byte(stim_q[i][15:8], $urandom_range(gmax, gmin));
            send_byte(stim_q[i][7:0], $urandom_range(gmax, gmin));
        end
        rx_valid = 1'b0;
        if (n > 0) begin
            tests++;
            if (wr_en !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL %s last_write: wr_en=%b done=%b, required wr_en=1 done=0", name, wr_en, done);
            end
            @(negedge clock);
        end
        tests++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0 || wr_en !== 1'b0 || rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s finish: done=%b cpu_reset=%b error=%b wr_en=%b rx_ready=%b, required 1 0 0 0 0",
                     name, done, cpu_reset, error, wr_en, rx_ready);
        end
        tests++;
        if (words_loaded !== nn) begin
            fails++;
            $display("FAIL %s words_loaded: got %0d, required %0d", name, words_loaded, n);
        end
        tests++;
        if (got_q.size() != n) begin
            fails++;
            $display("FAIL %s write_count: got %0d, required %0d", name, got_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                exp = {17'(i), stim_q[i]};
                tests++;
                if (got_q[i] !== exp) begin
                    fails++;
                    $display("FAIL %s write[%0d]: got %h, required %h", name, i, got_q[i], exp);
                end
            end
        end
        // Bytes offered in DONE must be ignored.
        rx_valid = 1'b1;
        rx_data  = 8'(($urandom));
        repeat (3) @(negedge clock);
        rx_valid = 1'b0;
        tests++;
        if (done !== 1'b1 || got_q.size() != n || words_loaded !== nn) begin
            fails++;
            $display("FAIL %s done_hold: done=%b writes=%0d words_loaded=%0d, required 1 %0d %0d",
                     name, done, got_q.size(), words_loaded, n, n);
        end
    endtask

    task automatic check_reset_values(input string name);
        tests++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0 || words_loaded !== 16'd0 ||
            cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL %s: wr_en=%b addr=%h data=%h wl=%0d cpu_reset=%b done=%b error=%b, required 0 0 0 0 1 0 0",
                     name, wr_en, wr_addr, wr_data, words_loaded, cpu_reset, done, error);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        restart  = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("reset_values");
        tests++;
        if (rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_rx_ready: got %b, required 0", rx_ready);
        end
        reset_n = 1'b1;
        #1;
        tests++;
        if (rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_rx_ready: got %b, required 1", rx_ready);
        end
        @(negedge clock);
    endtask

    task automatic test_basic();
        stim_q = '{16'h0002, 16'hEA88, 16'h0000};
        load_and_check(3, 0, 0, "basic");
        do_restart();
    endtask

    task automatic test_zero_length();
        stim_q.delete();
        load_and_check(0, 0, 0, "zero_len");
        do_restart();
    endtask

    task automatic test_error(input int n, input string name);
        logic [15:0] nn;
        nn = 16'(n);
        got_q.delete();
        send_byte(nn[15:8], 0);
        send_byte(nn[7:0], 0);
        rx_valid = 1'b1;
        rx_data  = 8'(($urandom));
        repeat (4) @(negedge clock);
        rx_valid = 1'b0;
        tests++;
        if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0 ||
            got_q.size() != 0 || words_loaded !== 16'd0) begin
            fails++;
            $display("FAIL %s state: error=%b cpu_reset=%b done=%b rx_ready=%b writes=%0d wl=%0d, required 1 1 0 0 0 0",
                     name, error, cpu_reset, done, rx_ready, got_q.size(), words_loaded);
        end
        do_restart();
        tests++;
        if (error !== 1'b0 || cpu_reset !== 1'b1 || rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s restart: error=%b cpu_reset=%b rx_ready=%b, required 0 1 1",
                     name, error, cpu_reset, rx_ready);
        end
        stim_q = '{16'(($urandom))};
        load_and_check(1, 0, 0, {name, "_reload"});
        do_restart();
    endtask

    task automatic test_valid_toggle();
        stim_q = '{16'hFC10};
        load_and_check(1, 1, 1, "valid_toggle");
        do_restart();
    endtask

    task automatic test_reset_midload();
        got_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        for (int i = 0; i < 2; i++) begin
            send_byte(8'(($urandom)), 0);
            send_byte(8'(($urandom)), 0);
        end
        rx_valid = 1'b0;
        reset_n  = 1'b0;
        @(negedge clock);
        check_reset_values("midload_reset_values");
        tests++;
        if (got_q.size() != 2 || rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL midload_writes: writes=%0d rx_ready=%b, required 2 0", got_q.size(), rx_ready);
        end
        reset_n = 1'b1;
        @(negedge clock);
        stim_q = '{16'h1234};
        load_and_check(1, 0, 0, "after_reset");
        do_restart();
    endtask

    task automatic test_restart_ignored();
        stim_q.delete();
        for (int i = 0; i < 3; i++) stim_q.push_back(16'(($urandom)));
        restart_word = 1;
        load_and_check(3, 0, 1, "restart_ignored");
        restart_word = -1;
        do_restart();
        tests++;
        if (cpu_reset !== 1'b1 || words_loaded !== 16'd0 || done !== 1'b0 || rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL restart_in_done: cpu_reset=%b wl=%0d done=%b rx_ready=%b, required 1 0 0 1",
                     cpu_reset, words_loaded, done, rx_ready);
        end
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(24, 1);
            stim_q.delete();
            for (int i = 0; i < n; i++) stim_q.push_back(16'(($urandom)));
            load_and_check(n, 0, 2, $sformatf("random%0d", t));
            do_restart();
        end
        test_error($urandom_range(65535, CAP + 1), "random_error");
    endtask

    task automatic test_full_capacity();
        stim_q.delete();
        for (int i = 0; i < CAP; i++) stim_q.push_back(16'(i * 40503 + 7));
        load_and_check(CAP, 0, 0, "full_capacity");
        do_restart();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_length();
        test_error(32769, "error_32769");
        test_valid_toggle();
        test_reset_midload();
        test_restart_ignored();
        test_random();
        test_full_capacity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
